// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes used by both the decoder and the
// execute-stage ALU, default datapath width, and the sequencer state type.
package alu_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_serial_shifter.sv
// Bit-serial shifter: one position per cycle, counting the shift amount down.
// done is a combinational pulse in the cycle whose edge produces the final value.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            dir_left,
    input  logic            arith,
    input  logic [XLEN-1:0] data_in,
    input  logic [SHW-1:0]  shamt,
    output logic [XLEN-1:0] shift_next,
    output logic            busy,
    output logic            done
);

    logic [XLEN-1:0] sreg_p0;
    logic [SHW-1:0]  cnt_p0;
    logic            left_p0;
    logic            arith_p0;
    logic            fill;

    // For SRA the MSB never changes while shifting right, so it still equals op_a's sign bit
    assign fill       = arith_p0 & sreg_p0[XLEN-1];
    assign shift_next = left_p0 ? {sreg_p0[XLEN-2:0], 1'b0} : {fill, sreg_p0[XLEN-1:1]};
    assign busy       = (cnt_p0 != '0);
    assign done       = (cnt_p0 == SHW'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= '0;
        end else if (load) begin
            cnt_p0 <= shamt;
        end else if (busy) begin
            cnt_p0 <= cnt_p0 - SHW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            sreg_p0  <= data_in;
            left_p0  <= dir_left;
            arith_p0 <= arith;
        end else if (busy) begin
            sreg_p0  <= shift_next;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/compare ops, serial
// shifts, valid/ready handshakes on both request and result sides.
module seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_ctrl,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal
);

    alu_state_e      state_q, state_d;
    logic            accept;
    logic            is_shift;
    logic            legal;
    logic            shift_load;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] sh_next;
    logic            sh_busy;
    logic            sh_done;

    // Shifts return op_a here; that is the answer for a zero shift amount
    function automatic logic [XLEN-1:0] alu_compute(input logic [3:0]      ctrl,
                                                    input logic [XLEN-1:0] a,
                                                    input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] a_s;
        logic signed [XLEN-1:0] b_s;
        logic [XLEN-1:0]        r;
        a_s = a;
        b_s = b;
        case (ctrl)
            ALU_ADD:                  r = a + b;
            ALU_SUB:                  r = a - b;
            ALU_SLT:                  r = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU:                 r = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:                  r = a ^ b;
            ALU_OR:                   r = a | b;
            ALU_AND:                  r = a & b;
            ALU_SLL, ALU_SRL, ALU_SRA: r = a;
            default:                  r = '0;
        endcase
        return r;
    endfunction

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign accept    = in_ready & in_valid;
    assign is_shift  = (alu_ctrl == ALU_SLL) | (alu_ctrl == ALU_SRL) | (alu_ctrl == ALU_SRA);
    assign legal     = (alu_ctrl <= ALU_AND);
    assign shamt     = op_b[SHW-1:0];
    assign alu_res   = alu_compute(alu_ctrl, op_a, op_b);

    alu_serial_shifter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (shift_load),
        .dir_left   (alu_ctrl == ALU_SLL),
        .arith      (alu_ctrl == ALU_SRA),
        .data_in    (op_a),
        .shamt      (shamt),
        .shift_next (sh_next),
        .busy       (sh_busy),
        .done       (sh_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift && (shamt != '0)) begin
                        shift_load = 1'b1;
                        state_d    = SHIFT;
                    end else begin
                        state_d    = DONE;
                    end
                end
            end
            SHIFT: begin
                if (sh_done || !sh_busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Result registers: loaded at acceptance, or at the final shift edge
    always_ff @(posedge clk) begin
        if (rst) begin
            result  <= '0;
            zero    <= 1'b0;
            illegal <= 1'b0;
        end else if (accept) begin
            result  <= alu_res;
            zero    <= (alu_res == '0);
            illegal <= ~legal;
        end else if ((state_q == SHIFT) && sh_done) begin
            result  <= sh_next;
            zero    <= (sh_next == '0);
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed plus randomized bench for seq_alu against an arithmetic reference model.
module tb_seq_alu;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    seq_alu #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        int unsigned        sh;
        sa = a;
        sb = b;
        sh = b % 32;
        case (c)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a << sh;
            4'd3:    return (sa < sb) ? 32'd1 : 32'd0;
            4'd4:    return (a < b) ? 32'd1 : 32'd0;
            4'd5:    return a ^ b;
            4'd6:    return a >> sh;
            4'd7:    return sa >>> sh;
            4'd8:    return a | b;
            4'd9:    return a & b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_latency(input logic [3:0] c, input logic [31:0] b);
        if (c == 4'd2 || c == 4'd6 || c == 4'd7) return int'(b % 32);
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request at a negedge, wait for the result, hold out_ready low for
    // 'hold' cycles (optionally presenting a competing request), then handshake.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input int hold, input bit bp_req);
        logic [31:0] exp_r;
        int          exp_lat;
        int          lat;
        exp_r   = ref_result(c, a, b);
        exp_lat = ref_latency(c, b);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        alu_ctrl = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".result"}, result, exp_r);
        chk({tag, ".zero"}, 32'(zero), 32'(exp_r == 32'd0));
        chk({tag, ".illegal"}, 32'(illegal), 32'(c > 4'd9));
        for (int i = 0; i < hold; i++) begin
            if (bp_req) begin
                in_valid = 1'b1;
                alu_ctrl = 4'd0;
                op_a     = 32'd100;
                op_b     = 32'd23;
            end
            @(negedge clk);
            chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, ".hold_result"}, result, exp_r);
            chk({tag, ".hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".post_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [3:0]  rc;
        logic [31:0] ra;
        logic [31:0] rb;
        int          seen_valid;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        alu_ctrl  = 4'd0;
        op_a      = 32'd0;
        op_b      = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk("reset.out_valid", 32'(out_valid), 32'd0);
        chk("reset.result", result, 32'd0);
        chk("reset.zero", 32'(zero), 32'd0);
        chk("reset.illegal", 32'(illegal), 32'd0);

        run_op("add", 4'd0, 32'd5, 32'd7, 0, 1'b0);
        run_op("sub", 4'd1, 32'd3, 32'd3, 0, 1'b0);
        run_op("slt", 4'd3, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        run_op("sltu", 4'd4, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
        run_op("xor", 4'd5, 32'hF0F0_F0F0, 32'hFFFF_0000, 0, 1'b0);
        run_op("sra", 4'd7, 32'h8000_0000, 32'h24, 0, 1'b0);
        run_op("srl", 4'd6, 32'h8000_0000, 32'h24, 0, 1'b0);
        run_op("sll0", 4'd2, 32'd1, 32'd0, 0, 1'b0);
        run_op("sll31", 4'd2, 32'd3, 32'd31, 1, 1'b0);
        run_op("bp_add", 4'd0, 32'd40, 32'd2, 3, 1'b1);
        run_op("bp_next", 4'd0, 32'd100, 32'd23, 0, 1'b0);
        run_op("illegal", 4'hF, 32'd9, 32'd9, 1, 1'b0);

        // Reset in the middle of a 20-bit left shift
        chk("rst_mid.in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        alu_ctrl = 4'd2;
        op_a     = 32'd1;
        op_b     = 32'd20;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid.in_ready_after", 32'(in_ready), 32'd1);
        chk("rst_mid.out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid.result", result, 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        chk("rst_mid.no_valid_pulse", 32'(seen_valid), 32'd0);
        run_op("add_after_rst", 4'd0, 32'd1, 32'd1, 0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            rc = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (n % 5 == 0) rb = ra;
            run_op($sformatf("rand%0d", n), rc, ra, rb, int'($urandom_range(0, 2)),
                   1'($urandom_range(0, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Multi-cycle integer ALU that executes the 4-bit `alu_ctrl` codes produced by the ALU decoder. It sits in the execute stage behind the decoder and accepts one operation at a time over a valid/ready handshake. It returns a registered result with a zero flag over a second valid/ready handshake. Logic and compare ops complete in one cycle; shifts use a serial shifter, one bit per cycle, to save area.

## Interface
Parameters:
- `XLEN`, 32 — operand/result width; must be a power of two ≥ 8.
- `SHW`, $clog2(XLEN) — shift-amount width; derived, not overridden.

Ports:
- `clk`  in  1  — single clock; everything is on the rising edge.
- `rst`  in  1  — reset, synchronous and active-high.
- `in_valid`  in  1  — operation request valid.
- `in_ready`  out  1  — block can accept a request.
- `alu_ctrl`  in  4  — operation code (encodings below).
- `op_a`  in  XLEN  — operand A (rs1).
- `op_b`  in  XLEN  — operand B (rs2 or immediate).
- `out_valid`  out  1  — result valid.
- `out_ready`  in  1  — consumer accepts the result.
- `result`  out  XLEN  — operation result.
- `zero`  out  1  — high when `result` == 0.
- `illegal`  out  1  — `alu_ctrl` was not a defined code.

## Operation
- Opcode encodings:
  - ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100.
  - XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
  - 1010–1111 are illegal.
- FSM states: IDLE, SHIFT, DONE. `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- In IDLE, when `in_valid` is high, the request is accepted and the inputs are captured. `op_a`, `op_b` and `alu_ctrl` are ignored at all other times.
- Non-shift op accepted: `result`, `zero` and `illegal` are registered at the accepting edge, and the FSM goes to DONE.
- Shift op accepted:
  - Load the shift register with `op_a`; load the counter with `op_b[SHW-1:0]`; upper bits of `op_b` are ignored.
  - Counter == 0: go to DONE with `result` = `op_a`.
  - Otherwise: go to SHIFT.
- SHIFT: each cycle shift by one bit and decrement the counter.
  - SLL fills with 0; SRL fills with 0; SRA fills with the captured `op_a[XLEN-1]`.
  - On the edge where the counter goes 1→0, move to DONE with the final value.
- DONE: hold `result`, `zero` and `illegal` stable until `out_ready` is high. Then go to IDLE.
- No new request is accepted in the DONE→IDLE cycle.
- Arithmetic rules:
  - ADD and SUB wrap modulo 2^XLEN; no carry or overflow output.
  - SLT: signed compare; SLTU: unsigned compare. Both return a zero-extended 0 or 1.
- Illegal code: `result` = 0, `zero` = 1, `illegal` = 1, 1-cycle latency.
- Reset mid-operation: state returns to IDLE and any in-flight operation is dropped. No `out_valid` pulse is produced for it.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `result` = 0, `zero` = 0, `illegal` = 0, internal counter = 0.
- Let edge N be the edge where the request is accepted. `out_valid` goes high:
  - after edge N for non-shift ops, illegal codes, and shifts with shamt 0;
  - after edge N+shamt for shifts.
- The earliest next acceptance is the edge after the DONE handshake edge. Throughput is at most one op per 2 cycles.
- `out_valid` stays high, and `result` stays stable, for as many cycles as `out_ready` is low.
- `in_ready` depends only on state. It has no combinational path from `in_valid` or `out_ready`.

## Structure
- Shared package `alu_pkg` holds:
  - the ALU_* 4-bit code constants, shared with the decoder;
  - the default `XLEN`;
  - the FSM state enum (IDLE, SHIFT, DONE).
- One sub-module: `alu_serial_shifter`.
  - Contains the shift register, down-counter, direction/arith control, and a `busy`/`done` pulse.
  - The top level contains the FSM, the one-cycle datapath, and the output registers.

## Test plan
- ADD 5, 7 → `result` = 12, `zero` = 0, `out_valid` the cycle after acceptance. SUB 3, 3 → `result` = 0, `zero` = 1.
- SLT 0xFFFFFFFF, 1 → 1. SLTU with the same operands → 0. XOR 0xF0F0F0F0, 0xFFFF0000 → 0x0F0FF0F0.
- SRA 0x80000000 by `op_b` = 0x24 (shamt 4) → 0xF8000000, `out_valid` 4 edges after acceptance. SRL of the same → 0x08000000. SLL 1 by 0 → 1 with 1-cycle latency.
- Back-pressure: hold `out_ready` low 3 cycles after ADD → `result` stable, `in_ready` = 0, the second request is not accepted. It is accepted the cycle after the handshake edge.
- `alu_ctrl` = 4'b1111 → `result` = 0, `illegal` = 1, `zero` = 1.
- Assert `rst` during SLL by 20 at shift cycle 5 → next cycle `in_ready` = 1, `out_valid` = 0, `result` = 0. A following ADD 1, 1 → 2.
